id_ex_stage: RTL and testbench

- Decode→execute pipeline register of the mspu core, feeding the EX-stage operand forwarding logic and ALU.
- Captures decoded operands and control each cycle and detects load-use hazards.
- Inserts bubbles, holds the IF/ID latch via stall_id, and applies memory-stall hold and branch flush with a pending-flush state.

---
 rtl/mspu_pipe_pkg.sv | 26 ++
 rtl/load_use_detect.sv | 21 ++
 rtl/id_ex_stage.sv | 133 +++++++++++++
 tb/tb_id_ex_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mspu_pipe_pkg.sv
// Shared types for the mspu decode/execute pipeline boundary.
package mspu_pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 16;

  typedef enum logic [0:0] {
    RUN,
    FLUSH_PEND
  } id_ex_state_t;

  typedef struct packed {
    logic              valid;
    logic              reg_we;
    logic              mem_re;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detect (
  input  logic       ex_valid,
  input  logic       mem_re_ex,
  input  logic [4:0] rd_ex,
  input  logic       id_valid,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       uses_rs1_id,
  input  logic       uses_rs2_id,
  output logic       hazard
);

  logic src_match;

  always_comb begin
    src_match = (uses_rs1_id && (rs1_id == rd_ex)) || (uses_rs2_id && (rs2_id == rd_ex));
    hazard    = ex_valid && mem_re_ex && (rd_ex != 5'd0) && id_valid && src_match;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubbles, memory-stall hold and deferred flush.
// Optional ID_EX_BUBBLE_CNT_EN adds a 32-bit count of captured bubbles.
module id_ex_stage #(
  parameter int unsigned XLEN   = mspu_pipe_pkg::XLEN,
  parameter int unsigned CTRL_W = mspu_pipe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        rs1_id,
  input  logic [4:0]        rs2_id,
  input  logic              uses_rs1_id,
  input  logic              uses_rs2_id,
  input  logic [4:0]        rd_id,
  input  logic              reg_we_id,
  input  logic              mem_re_id,
  input  logic [XLEN-1:0]   alu_a_id,
  input  logic [XLEN-1:0]   alu_b_id,
  input  logic [XLEN-1:0]   imm_id,
  input  logic [XLEN-1:0]   pc_id,
  input  logic [CTRL_W-1:0] ctrl_id,
  input  logic              flush,
  input  logic              mem_stall,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [4:0]        rs1_ex,
  output logic [4:0]        rs2_ex,
  output logic [4:0]        rd_ex,
  output logic              reg_we_ex,
  output logic              mem_re_ex,
  output logic [XLEN-1:0]   alu_a_ex,
  output logic [XLEN-1:0]   alu_b_ex,
  output logic [XLEN-1:0]   imm_ex,
  output logic [XLEN-1:0]   pc_ex,
  output logic [CTRL_W-1:0] ctrl_ex
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0]       bubble_cnt
`endif
);

  import mspu_pipe_pkg::*;

  id_ex_t       ex_q, ex_d;
  id_ex_state_t state_q, state_d;
  logic         hazard;
  logic         bubble;

  load_use_detect u_load_use_detect (
    .ex_valid    (ex_q.valid),
    .mem_re_ex   (ex_q.mem_re),
    .rd_ex       (ex_q.rd),
    .id_valid    (id_valid),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .uses_rs1_id (uses_rs1_id),
    .uses_rs2_id (uses_rs2_id),
    .hazard      (hazard)
  );

  always_comb begin
    ex_d    = ex_q;
    state_d = state_q;
    bubble  = 1'b0;
    if (mem_stall) begin
      if (flush) state_d = FLUSH_PEND;
    end else if (state_q == FLUSH_PEND) begin
      bubble  = 1'b1;
      state_d = RUN;
    end else if (flush || hazard) begin
      bubble = 1'b1;
    end else begin
      ex_d.valid  = id_valid;
      ex_d.reg_we = reg_we_id & id_valid;
      ex_d.mem_re = mem_re_id & id_valid;
      ex_d.rs1    = rs1_id;
      ex_d.rs2    = rs2_id;
      ex_d.rd     = rd_id;
      ex_d.alu_a  = alu_a_id;
      ex_d.alu_b  = alu_b_id;
      ex_d.imm    = imm_id;
      ex_d.pc     = pc_id;
      ex_d.ctrl   = ctrl_id;
    end
    // Bubbles only kill the control bits; datapath fields keep their old values.
    if (bubble) begin
      ex_d.valid  = 1'b0;
      ex_d.reg_we = 1'b0;
      ex_d.mem_re = 1'b0;
    end
  end

  always_comb begin
    stall_id = !reset && (mem_stall || ((state_q == RUN) && !flush && hazard));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= '0;
      state_q <= RUN;
    end else begin
      ex_q    <= ex_d;
      state_q <= state_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
    end else if (bubble) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

  assign ex_valid  = ex_q.valid;
  assign rs1_ex    = ex_q.rs1;
  assign rs2_ex    = ex_q.rs2;
  assign rd_ex     = ex_q.rd;
  assign reg_we_ex = ex_q.reg_we;
  assign mem_re_ex = ex_q.mem_re;
  assign alu_a_ex  = ex_q.alu_a;
  assign alu_b_ex  = ex_q.alu_b;
  assign imm_ex    = ex_q.imm;
  assign pc_ex     = ex_q.pc;
  assign ctrl_ex   = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; bubble counter checks need ID_EX_BUBBLE_CNT_EN.
module tb_id_ex_stage;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [4:0]        rs1_id, rs2_id, rd_id;
  logic              uses_rs1_id, uses_rs2_id;
  logic              reg_we_id, mem_re_id;
  logic [XLEN-1:0]   alu_a_id, alu_b_id, imm_id, pc_id;
  logic [CTRL_W-1:0] ctrl_id;
  logic              flush, mem_stall;
  logic              stall_id, ex_valid;
  logic [4:0]        rs1_ex, rs2_ex, rd_ex;
  logic              reg_we_ex, mem_re_ex;
  logic [XLEN-1:0]   alu_a_ex, alu_b_ex, imm_ex, pc_ex;
  logic [CTRL_W-1:0] ctrl_ex;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0]       bubble_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(
    .XLEN   (XLEN),
    .CTRL_W (CTRL_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .uses_rs1_id (uses_rs1_id),
    .uses_rs2_id (uses_rs2_id),
    .rd_id       (rd_id),
    .reg_we_id   (reg_we_id),
    .mem_re_id   (mem_re_id),
    .alu_a_id    (alu_a_id),
    .alu_b_id    (alu_b_id),
    .imm_id      (imm_id),
    .pc_id       (pc_id),
    .ctrl_id     (ctrl_id),
    .flush       (flush),
    .mem_stall   (mem_stall),
    .stall_id    (stall_id),
    .ex_valid    (ex_valid),
    .rs1_ex      (rs1_ex),
    .rs2_ex      (rs2_ex),
    .rd_ex       (rd_ex),
    .reg_we_ex   (reg_we_ex),
    .mem_re_ex   (mem_re_ex),
    .alu_a_ex    (alu_a_ex),
    .alu_b_ex    (alu_b_ex),
    .imm_ex      (imm_ex),
    .pc_ex       (pc_ex),
    .ctrl_ex     (ctrl_ex)
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    .bubble_cnt  (bubble_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it so registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [XLEN-1:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2, input logic we,
                        input logic re);
    id_valid    = 1'b1;
    pc_id       = pc;
    rd_id       = rd;
    rs1_id      = rs1;
    rs2_id      = rs2;
    uses_rs1_id = u1;
    uses_rs2_id = u2;
    reg_we_id   = we;
    mem_re_id   = re;
    #1;
  endtask

  initial begin
    reset = 1'b1;  mem_stall = 1'b0;  flush = 1'b0;
    alu_a_id = 32'h0;  alu_b_id = 32'h11;  imm_id = 32'h22;  ctrl_id = 16'hA5A5;
    set_id(32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset held two edges with a valid instruction present.
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("rst_ex_valid", ex_valid, 0);
      check_eq("rst_reg_we", reg_we_ex, 0);
      check_eq("rst_stall", stall_id, 0);
    end
    check_eq("rst_pc", pc_ex, 0);
    reset = 1'b0;
    step();
    check_eq("first_pc", pc_ex, 32'h100);
    check_eq("first_valid", ex_valid, 1);
    check_eq("first_ctrl", ctrl_ex, 16'hA5A5);

    // lw x5 then add x6,x5,x1: one bubble.
    set_id(32'h104, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check_eq("lw_mem_re", mem_re_ex, 1);
    check_eq("lw_rd", rd_ex, 5);
    set_id(32'h108, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("lu_stall", stall_id, 1);
    step();
    check_eq("lu_bubble_valid", ex_valid, 0);
    check_eq("lu_bubble_we", reg_we_ex, 0);
    check_eq("lu_bubble_re", mem_re_ex, 0);
    check_eq("lu_stall_clear", stall_id, 0);
    step();
    check_eq("lu_adv_valid", ex_valid, 1);
    check_eq("lu_adv_rs1", rs1_ex, 5);
    check_eq("lu_adv_pc", pc_ex, 32'h108);

    // Load to x0 never stalls.
    set_id(32'h10C, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    set_id(32'h110, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("rd0_stall", stall_id, 0);
    step();
    check_eq("rd0_adv_pc", pc_ex, 32'h110);

    // Load rd=7, ID names rs2=7 but does not read it.
    set_id(32'h114, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    set_id(32'h118, 5'd8, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("nouse_stall", stall_id, 0);
    step();
    check_eq("nouse_adv_pc", pc_ex, 32'h118);

    // Non-load producer x8 in EX, consumer reads x8: forwarding, no stall.
    alu_a_id = 32'hDEADBEEF;
    set_id(32'h120, 5'd10, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("alu_dep_stall", stall_id, 0);
    step();
    check_eq("alu_a_cap", alu_a_ex, 32'hDEADBEEF);

    // Three-cycle memory stall holds everything.
    alu_a_id  = 32'h12345678;
    set_id(32'h124, 5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    mem_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("ms_stall", stall_id, 1);
      step();
      check_eq("ms_alu_a", alu_a_ex, 32'hDEADBEEF);
      check_eq("ms_pc", pc_ex, 32'h120);
      check_eq("ms_valid", ex_valid, 1);
    end
    mem_stall = 1'b0;
    step();
    check_eq("ms_release_pc", pc_ex, 32'h124);

    // Flush during first cycle of a two-cycle stall: deferred bubble.
    set_id(32'h128, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    mem_stall = 1'b1;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    check_eq("fp_hold1_pc", pc_ex, 32'h124);
    check_eq("fp_hold1_valid", ex_valid, 1);
    step();
    check_eq("fp_hold2_pc", pc_ex, 32'h124);
    mem_stall = 1'b0;
    #1;
    check_eq("fp_stall", stall_id, 0);
    step();
    check_eq("fp_bubble", ex_valid, 0);
    step();
    check_eq("fp_resume_pc", pc_ex, 32'h128);
    check_eq("fp_resume_valid", ex_valid, 1);

    // Flush with no valid ID instruction still bubbles.
    id_valid = 1'b0;
    flush    = 1'b1;
    #1;
    check_eq("fl_stall", stall_id, 0);
    step();
    flush = 1'b0;
    check_eq("fl_bubble", ex_valid, 0);
`ifdef ID_EX_BUBBLE_CNT_EN
    check_eq("bubble_cnt", bubble_cnt, 3);
`endif

    // Reset while stalled in the pending-flush state.
    set_id(32'h12C, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    mem_stall = 1'b1;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("rst_mid_stall", stall_id, 0);
    step();
    check_eq("rst_mid_pc", pc_ex, 0);
    check_eq("rst_mid_valid", ex_valid, 0);
`ifdef ID_EX_BUBBLE_CNT_EN
    check_eq("bubble_cnt_rst", bubble_cnt, 0);
`endif
    reset     = 1'b0;
    mem_stall = 1'b0;
    set_id(32'h200, 5'd14, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("post_rst_pc", pc_ex, 32'h200);
    check_eq("post_rst_valid", ex_valid, 1);

    // Invalid ID gates write-enable and load flags.
    set_id(32'h204, 5'd15, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    id_valid = 1'b0;
    step();
    check_eq("inv_valid", ex_valid, 0);
    check_eq("inv_we", reg_we_ex, 0);
    check_eq("inv_re", mem_re_ex, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
